// File: rtl/tictactoe_pkg.sv
// Shared TicTacToe types: command encoding, board geometry and the mouse hit-test helpers.
package tictactoe_pkg;

  localparam int unsigned NUM_SRC   = 4;
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned HIT_W     = 11;

  localparam int unsigned SRC_ONOFF = 0;
  localparam int unsigned SRC_MOUSE = 1;
  localparam int unsigned SRC_LEFT  = 2;
  localparam int unsigned SRC_RIGHT = 3;

  localparam int unsigned GEO_BOARD_LEFT = 185;
  localparam int unsigned GEO_BOARD_TOP  = 140;
  localparam int unsigned GEO_CELL_W     = 84;
  localparam int unsigned GEO_BAR_W      = 9;

  localparam logic [3:0] CELL_MISS = 4'hF;

  typedef enum logic [1:0] {
    CMD_ONOFF = 2'd0,
    CMD_CLICK = 2'd1,
    CMD_LEFT  = 2'd2,
    CMD_RIGHT = 2'd3
  } cmd_type_e;

  // Index 0..2 of the cell span containing pos along one axis, 3 when on a bar or off-board.
  function automatic logic [1:0] axis_hit(input logic [COORD_W-1:0] pos,
                                          input logic [HIT_W-1:0]   origin,
                                          input logic [HIT_W-1:0]   span,
                                          input logic [HIT_W-1:0]   bar);
    logic [HIT_W-1:0] p;
    logic [HIT_W-1:0] lo;
    axis_hit = 2'd3;
    p = HIT_W'(pos);
    for (int c = 0; c < 3; c++) begin
      lo = origin + HIT_W'(c) * (span + bar);
      if (p >= lo && p <= lo + span) axis_hit = 2'(c);
    end
  endfunction

  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    if (row == 2'd3 || col == 2'd3) cell_index = CELL_MISS;
    else                            cell_index = 4'(row) * 4'd3 + 4'(col);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Per-source synchroniser, rising-edge detector and post-acceptance lockout counter.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic accept_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             prev;
  logic [CNT_W-1:0] deb_q;
  logic [CNT_W-1:0] deb_d;

  assign accept_c = sync2 & ~prev & (deb_q == '0);

  always_comb begin
    deb_d = deb_q;
    if (accept_c)          deb_d = RELOAD;
    else if (deb_q != '0)  deb_d = deb_q - CNT_W'(1);
  end

  // Sync chain resets high so a level held across reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      deb_q <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      deb_q <= deb_d;
    end
  end

endmodule

// File: rtl/input_event_arbiter.sv
// Turns four raw player inputs into one-at-a-time game commands over a valid/ready handshake.
module input_event_arbiter
  import tictactoe_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BOARD_LEFT      = GEO_BOARD_LEFT,
  parameter int unsigned BOARD_TOP       = GEO_BOARD_TOP,
  parameter int unsigned CELL_W          = GEO_CELL_W,
  parameter int unsigned BAR_W           = GEO_BAR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Boton_onoff,
  input  logic               Boton_izquierda,
  input  logic               Boton_derecha,
  input  logic               mouseBotton,
  input  logic [COORD_W-1:0] mouseX,
  input  logic [COORD_W-1:0] mouseY,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_type,
  output logic [3:0]         cmd_cell,
  output logic               event_dropped
);

  typedef enum logic {ST_IDLE, ST_OFFER} state_e;

  logic [NUM_SRC-1:0] raw;
  logic [NUM_SRC-1:0] accept_c;
  logic [NUM_SRC-1:0] pend_q, pend_d, clr;
  logic [3:0]         hit_cell_c;
  logic [3:0]         mouse_cell_q, mouse_cell_d;
  state_e             state_q, state_d;
  cmd_type_e          type_q, type_d;
  logic [3:0]         cell_q, cell_d;
  logic               valid_q, valid_d;
  logic               drop_q, drop_d;

  assign raw = {Boton_derecha, Boton_izquierda, mouseBotton, Boton_onoff};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw[i]),
      .accept_c (accept_c[i])
    );
  end

  assign hit_cell_c = cell_index(
    axis_hit(mouseY, HIT_W'(BOARD_TOP),  HIT_W'(CELL_W), HIT_W'(BAR_W)),
    axis_hit(mouseX, HIT_W'(BOARD_LEFT), HIT_W'(CELL_W), HIT_W'(BAR_W)));

  // Arbiter next state, pending bookkeeping and mouse-cell capture.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cell_d  = cell_q;
    valid_d = valid_q;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d = ST_OFFER;
          valid_d = 1'b1;
          cell_d  = CELL_MISS;
          if (pend_q[SRC_ONOFF]) begin
            type_d = CMD_ONOFF;
            clr[SRC_ONOFF] = 1'b1;
          end else if (pend_q[SRC_MOUSE]) begin
            type_d = CMD_CLICK;
            cell_d = mouse_cell_q;
            clr[SRC_MOUSE] = 1'b1;
          end else if (pend_q[SRC_LEFT]) begin
            type_d = CMD_LEFT;
            clr[SRC_LEFT] = 1'b1;
          end else begin
            type_d = CMD_RIGHT;
            clr[SRC_RIGHT] = 1'b1;
          end
        end
      end
      ST_OFFER: begin
        if (cmd_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    // A same-cycle set beats the grant's clear.
    pend_d = (pend_q & ~clr) | accept_c;
    drop_d = |(accept_c & pend_q & ~clr);
    mouse_cell_d = mouse_cell_q;
    if (accept_c[SRC_MOUSE] && (!pend_q[SRC_MOUSE] || clr[SRC_MOUSE])) mouse_cell_d = hit_cell_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      type_q       <= CMD_ONOFF;
      cell_q       <= CELL_MISS;
      valid_q      <= 1'b0;
      drop_q       <= 1'b0;
      pend_q       <= '0;
      mouse_cell_q <= CELL_MISS;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      cell_q       <= cell_d;
      valid_q      <= valid_d;
      drop_q       <= drop_d;
      pend_q       <= pend_d;
      mouse_cell_q <= mouse_cell_d;
    end
  end

  assign cmd_valid     = valid_q;
  assign cmd_type      = type_q;
  assign cmd_cell      = cell_q;
  assign event_dropped = drop_q;

endmodule

// File: tb/tb_input_event_arbiter.sv
// Scoreboard bench for input_event_arbiter: directed presses, a monitor pops expected commands on transfer.
module tb_input_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Boton_onoff, Boton_izquierda, Boton_derecha, mouseBotton;
  logic [9:0] mouseX, mouseY;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_type;
  logic [3:0] cmd_cell;
  logic       event_dropped;

  typedef struct {
    int t;
    int c;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_xfer = 0;
  int   n_drop = 0;

  always #5 clk = ~clk;

  input_event_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Boton_onoff     (Boton_onoff),
    .Boton_izquierda (Boton_izquierda),
    .Boton_derecha   (Boton_derecha),
    .mouseBotton     (mouseBotton),
    .mouseX          (mouseX),
    .mouseY          (mouseY),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_type        (cmd_type),
    .cmd_cell        (cmd_cell),
    .event_dropped   (event_dropped)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles && !cmd_valid; i++) tick();
    chk("wait_valid", int'(cmd_valid), 1);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    chk("drain", sb.size(), 0);
  endtask

  task automatic monitor();
    bit       prev_xfer = 0;
    bit       prev_stall = 0;
    int       prev_type = 0;
    int       prev_cell = 0;
    exp_t     e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_xfer  = 0;
        prev_stall = 0;
      end else begin
        if (prev_xfer) chk("idle_gap", int'(cmd_valid), 0);
        if (prev_stall) begin
          chk("hold_valid", int'(cmd_valid), 1);
          chk("hold_type", int'(cmd_type), prev_type);
          chk("hold_cell", int'(cmd_cell), prev_cell);
        end
        if (event_dropped) n_drop++;
        if (cmd_valid && cmd_ready) begin
          n_xfer++;
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_cmd: got type %0d cell %0d, expected none at %0t",
                     cmd_type, cmd_cell, $time);
          end else begin
            e = sb.pop_front();
            chk("cmd_type", int'(cmd_type), e.t);
            chk("cmd_cell", int'(cmd_cell), e.c);
          end
        end
        prev_xfer  = cmd_valid && cmd_ready;
        prev_stall = cmd_valid && !cmd_ready;
        prev_type  = int'(cmd_type);
        prev_cell  = int'(cmd_cell);
      end
    end
  endtask

  initial begin
    int xfer0;
    int drop0;
    rst_n = 1'b0;
    {Boton_onoff, Boton_izquierda, Boton_derecha, mouseBotton} = 4'b0;
    mouseX = 10'd0;
    mouseY = 10'd0;
    cmd_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) tick();
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_type", int'(cmd_type), 0);
    chk("rst_cell", int'(cmd_cell), 15);
    chk("rst_dropped", int'(event_dropped), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Click in cell 0: valid appears on the fourth edge after the input is driven.
    mouseX = 10'd200;
    mouseY = 10'd150;
    sb.push_back('{t: 1, c: 0});
    mouseBotton = 1'b1;
    repeat (3) tick();
    chk("lat_not_yet", int'(cmd_valid), 0);
    tick();
    chk("lat_valid", int'(cmd_valid), 1);
    mouseBotton = 1'b0;
    tick();
    chk("single_cycle", int'(cmd_valid), 0);
    drain(20);
    repeat (8) tick();

    // Click on the vertical bar between columns 0 and 1.
    mouseX = 10'd272;
    sb.push_back('{t: 1, c: 15});
    mouseBotton = 1'b1;
    repeat (2) tick();
    mouseBotton = 1'b0;
    drain(20);
    repeat (8) tick();

    // Cell 8 held under back-pressure, then exactly one transfer.
    xfer0 = n_xfer;
    cmd_ready = 1'b0;
    mouseX = 10'd400;
    mouseY = 10'd340;
    sb.push_back('{t: 1, c: 8});
    mouseBotton = 1'b1;
    repeat (2) tick();
    mouseBotton = 1'b0;
    wait_valid(10);
    repeat (10) tick();
    chk("stall_valid", int'(cmd_valid), 1);
    chk("stall_cell", int'(cmd_cell), 8);
    cmd_ready = 1'b1;
    drain(20);
    repeat (5) tick();
    chk("stall_one_xfer", n_xfer - xfer0, 1);
    repeat (5) tick();

    // All four in the same cycle: priority order, cursor in cell 4.
    mouseX = 10'd300;
    mouseY = 10'd250;
    sb.push_back('{t: 0, c: 15});
    sb.push_back('{t: 1, c: 4});
    sb.push_back('{t: 2, c: 15});
    sb.push_back('{t: 3, c: 15});
    {Boton_onoff, Boton_izquierda, Boton_derecha, mouseBotton} = 4'b1111;
    repeat (2) tick();
    {Boton_onoff, Boton_izquierda, Boton_derecha, mouseBotton} = 4'b0000;
    drain(40);
    repeat (8) tick();

    // Bouncy left press behind a stalled ONOFF, then a second press that coalesces.
    xfer0 = n_xfer;
    drop0 = n_drop;
    cmd_ready = 1'b0;
    sb.push_back('{t: 0, c: 15});
    sb.push_back('{t: 2, c: 15});
    Boton_onoff = 1'b1;
    Boton_izquierda = 1'b1;
    tick();
    Boton_onoff = 1'b0;
    Boton_izquierda = 1'b0;
    tick();
    Boton_izquierda = 1'b1;
    tick();
    Boton_izquierda = 1'b0;
    repeat (6) tick();
    chk("no_drop_in_lockout", n_drop - drop0, 0);
    Boton_izquierda = 1'b1;
    repeat (2) tick();
    Boton_izquierda = 1'b0;
    repeat (6) tick();
    chk("drop_pulse", n_drop - drop0, 1);
    cmd_ready = 1'b1;
    drain(40);
    repeat (10) tick();
    chk("bounce_xfers", n_xfer - xfer0, 2);

    // Buttons held through reset release produce nothing.
    xfer0 = n_xfer;
    {Boton_onoff, Boton_izquierda, Boton_derecha, mouseBotton} = 4'b1111;
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    {Boton_onoff, Boton_izquierda, Boton_derecha, mouseBotton} = 4'b0000;
    repeat (10) tick();
    chk("held_no_cmd", n_xfer - xfer0, 0);
    chk("held_valid", int'(cmd_valid), 0);

    // Reset in the middle of an offer discards it.
    cmd_ready = 1'b0;
    Boton_derecha = 1'b1;
    repeat (2) tick();
    Boton_derecha = 1'b0;
    wait_valid(10);
    Boton_onoff = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(cmd_valid), 0);
    chk("mid_rst_cell", int'(cmd_cell), 15);
    tick();
    Boton_onoff = 1'b0;
    tick();
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    repeat (20) tick();
    chk("mid_rst_no_cmd", n_xfer - xfer0, 0);

    chk("sb_empty", sb.size(), 0);
    chk("dropped_total", n_drop, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
